// File: rtl/shift_mult_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding
// and the default operand width used by the register, controller and top level.
package shift_mult_pkg;

  localparam int MULT_N = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    EVAL  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/shift_mult_controller_if.sv
// Control bundle between the shift-add sequencer and the A/Q/C datapath register.
// Handshake: start is a level request sampled only while idle; done is a one-cycle pulse.
interface shift_mult_controller_if
  import shift_mult_pkg::*;
#(
  parameter int N = MULT_N
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic          start;
  logic          abort;
  logic          q0;
  logic          init;
  logic          add;
  logic          shift;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  modport slave (
    input  start, abort, q0,
    output init, add, shift, busy, done, count
  );

  modport master (
    output start, abort, q0,
    input  init, add, shift, busy, done, count
  );

endinterface

// File: rtl/shift_mult_controller.sv
// Sequencing FSM for the shift-add multiplier: init, then per multiplier bit
// an optional add (when Q[0]=1) followed by a shift, then a one-cycle done.
module shift_mult_controller
  import shift_mult_pkg::*;
#(
  parameter int N = MULT_N
)
(
  input  logic                  clock,
  input  logic                  reset,
  shift_mult_controller_if.slave bus,
  output state_t                o_state
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_next       = IDLE;
    w_count_next = r_count;
    case (r_state)
      IDLE:  w_next = bus.start ? INIT : IDLE;
      INIT: begin
        w_next       = EVAL;
        w_count_next = '0;
      end
      EVAL:  w_next = bus.q0 ? ADD : SHIFT;
      ADD:   w_next = SHIFT;
      SHIFT: begin
        if (r_count == LAST) begin
          w_next = DONE;
        end else begin
          w_next       = EVAL;
          w_count_next = r_count + CW'(1);
        end
      end
      DONE: begin
        w_next       = IDLE;
        w_count_next = '0;
      end
      default: begin
        w_next       = IDLE;
        w_count_next = '0;
      end
    endcase
    // Abort overrides every busy state; the op decoded this cycle still completes.
    if (r_state != IDLE && bus.abort) begin
      w_next       = IDLE;
      w_count_next = '0;
    end
  end

  assign bus.init  = (r_state == INIT);
  assign bus.add   = (r_state == ADD);
  assign bus.shift = (r_state == SHIFT);
  assign bus.done  = (r_state == DONE);
  assign bus.busy  = (r_state == INIT) || (r_state == EVAL) || (r_state == ADD) ||
                     (r_state == SHIFT) || (r_state == DONE);
  assign bus.count = r_count;
  assign o_state   = r_state;

endmodule

// File: tb/tb_shift_mult_controller.sv
// Bench for shift_mult_controller: drives it beside a behavioural A/Q/C register
// and checks control sequencing, latency and products against arithmetic expectations.
module tb_shift_mult_controller;
  import shift_mult_pkg::*;

  localparam int N = MULT_N;

  logic   clock;
  logic   reset;
  state_t o_state;

  shift_mult_controller_if #(.N(N)) bus ();

  shift_mult_controller #(.N(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .o_state (o_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // datapath register the controller sequences
  logic [N-1:0] r_a, r_q, mplier, mcand;
  logic         r_c;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a <= '0; r_q <= '0; r_c <= 1'b0;
    end else if (bus.init) begin
      r_a <= '0; r_q <= mplier; r_c <= 1'b0;
    end else if (bus.add) begin
      {r_c, r_a} <= {1'b0, r_a} + {1'b0, mcand};
    end else if (bus.shift) begin
      {r_c, r_a, r_q} <= {1'b0, r_c, r_a, r_q[N-1:1]};
    end
  end
  assign bus.q0 = r_q[0];

  int checks = 0;
  int errors = 0;

  // scoreboard: {op, bit index}; op 2 = add, 3 = shift
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  // driver: one start pulse, then observe until done (or timeout)
  task automatic do_mult(input logic [N-1:0] mp, input logic [N-1:0] mc,
                         output int lat, output int prod, output int n_done,
                         output int n_multi, output int got_init);
    obs_q.delete();
    mplier = mp; mcand = mc;
    lat = -1; prod = 0; n_done = 0; n_multi = 0;
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    got_init = int'(bus.init);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (int'(bus.init) + int'(bus.add) + int'(bus.shift) > 1) n_multi++;
      if (bus.add)   obs_q.push_back({4'd2, 4'(bus.count)});
      if (bus.shift) obs_q.push_back({4'd3, 4'(bus.count)});
      if (bus.done) begin
        n_done++;
        if (lat < 0) begin lat = k; prod = int'({r_a, r_q}); end
      end
      if (lat >= 0 && k >= lat + 3) break;
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    mplier = '0; mcand = '0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    checks++;
    if ({bus.init, bus.add, bus.shift, bus.busy, bus.done} !== 5'b0 || bus.count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b count=%0d expected ctl=00000 count=0",
               {bus.init, bus.add, bus.shift, bus.busy, bus.done}, bus.count);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ({bus.init, bus.add, bus.shift, bus.busy, bus.done} !== 5'b0 ||
          bus.count !== '0 || o_state !== IDLE) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold: got %0d non-idle cycles expected 0", bad);
    end
  endtask

  task automatic test_mult(input logic [N-1:0] mp, input logic [N-1:0] mc, input string nm);
    int lat, prod, n_done, n_multi, got_init, exp_lat, seq_bad;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (mp[i]) exp_q.push_back({4'd2, 4'(i)});
      exp_q.push_back({4'd3, 4'(i)});
    end
    exp_lat = 1 + 2 * N + $countones(mp);
    do_mult(mp, mc, lat, prod, n_done, n_multi, got_init);
    checks++;
    if (got_init != 1) begin
      errors++; $display("FAIL %s_init: got %0d expected 1", nm, got_init);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat);
    end
    checks++;
    if (prod != int'(mp) * int'(mc)) begin
      errors++; $display("FAIL %s_product: got %0d expected %0d", nm, prod, int'(mp) * int'(mc));
    end
    checks++;
    if (n_done != 1) begin
      errors++; $display("FAIL %s_done_pulses: got %0d expected 1", nm, n_done);
    end
    checks++;
    if (n_multi != 0) begin
      errors++; $display("FAIL %s_onehot: got %0d overlap cycles expected 0", nm, n_multi);
    end
    seq_bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
    if (seq_bad == 0)
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) seq_bad = 1;
    checks++;
    if (seq_bad != 0) begin
      errors++;
      $display("FAIL %s_sequence: got %0d ops expected %0d ops (or op/index differs)",
               nm, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int init_t[$], done_t[$], prod_bad;
    mplier = 4'd5; mcand = 4'($urandom_range(1, 15));
    prod_bad = 0;
    @(negedge clock); bus.start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (bus.init) init_t.push_back(k);
      if (bus.done) begin
        done_t.push_back(k);
        if (int'({r_a, r_q}) != 5 * int'(mcand)) prod_bad++;
      end
      if (done_t.size() == 2) break;
    end
    bus.start = 1'b0;
    checks++;
    if (done_t.size() != 2 || init_t.size() != 2) begin
      errors++;
      $display("FAIL b2b_counts: got %0d dones %0d inits expected 2 and 2", done_t.size(), init_t.size());
    end else begin
      checks++;
      if (done_t[1] - done_t[0] != 13) begin
        errors++; $display("FAIL b2b_done_gap: got %0d expected 13", done_t[1] - done_t[0]);
      end
      checks++;
      if (done_t[0] - init_t[0] != 11) begin
        errors++; $display("FAIL b2b_first_latency: got %0d expected 11", done_t[0] - init_t[0]);
      end
    end
    checks++;
    if (prod_bad != 0) begin
      errors++; $display("FAIL b2b_product: got %0d bad products expected 0", prod_bad);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_after: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_abort();
    int found, n_done;
    mplier = 4'($urandom_range(0, 15)) | 4'd1; mcand = 4'($urandom_range(1, 15));
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clock);
      if (bus.add) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++; $display("FAIL abort_add_seen: got 0 expected 1");
    end
    @(negedge clock); bus.abort = 1'b1;
    @(negedge clock); bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.count !== '0 || o_state !== IDLE) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b count=%0d state=%0d expected 0 0 0", bus.busy, bus.count, o_state);
    end
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (bus.done) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d expected 0", n_done);
    end
    // start and abort together while idle: start wins
    @(negedge clock); bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clock); bus.start = 1'b0; bus.abort = 1'b0;
    checks++;
    if (bus.init !== 1'b1) begin
      errors++; $display("FAIL abort_start_idle: got init=%b expected 1", bus.init);
    end
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clock);
      if (bus.done) found = 1;
    end
    checks++;
    if (found == 0 || int'({r_a, r_q}) != int'(mplier) * int'(mcand)) begin
      errors++;
      $display("FAIL abort_start_result: got done=%0d prod=%0d expected 1 %0d",
               found, int'({r_a, r_q}), int'(mplier) * int'(mcand));
    end
    test_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "after_abort");
  endtask

  task automatic test_reset_mid();
    int found;
    mplier = 4'($urandom_range(0, 15)); mcand = 4'($urandom_range(0, 15));
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clock);
      if (bus.shift) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++; $display("FAIL rst_mid_shift_seen: got 0 expected 1");
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.shift !== 1'b0 || bus.busy !== 1'b0 || o_state !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_async: got shift=%b busy=%b state=%0d expected 0 0 0", bus.shift, bus.busy, o_state);
    end
    @(negedge clock); reset = 1'b0;
    test_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "after_reset");
  endtask

  initial begin
    test_reset();
    test_mult(4'd5, 4'd4, "mult5x4");
    test_mult(4'd0, 4'($urandom_range(1, 15)), "mult0");
    test_mult(4'd15, 4'($urandom_range(1, 15)), "mult15");
    for (int i = 0; i < 8; i++)
      test_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
